fb_rect_fill: RTL and testbench

Upstream drawing engine for the VGA framebuffer: accepts one rectangle command (position, size, RGB565 colour) per handshake. Clips the rectangle to the screen and emits one Avalon-MM pixel write per covered pixel, in raster order. Its master port connects directly to the slave write port of the VGA Avalon interface (17-bit word address, 16-bit data). Used by the game logic to draw and erase puck, paddles and field areas.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_rect_clip.sv | 32 +++
 rtl/fb_rect_fill.sv | 129 ++++++++++++
 tb/tb_fb_rect_fill.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, RGB565 colour constants and fill-engine state encoding.
package fb_pkg;

    localparam int unsigned H_RES  = 320;
    localparam int unsigned V_RES  = 240;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] BLACK = 16'h0000;
    localparam logic [DATA_W-1:0] RED   = 16'hF800;
    localparam logic [DATA_W-1:0] GREEN = 16'h07E0;
    localparam logic [DATA_W-1:0] BLUE  = 16'h001F;
    localparam logic [DATA_W-1:0] WHITE = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clip of a rectangle to the screen plus the first row's base address.
module fb_rect_clip
    import fb_pkg::*;
(
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic [9:0]        w,
    input  logic [8:0]        h,
    output logic [10:0]       x_end,
    output logic [9:0]        y_end,
    output logic [ADDR_W-1:0] row_base,
    output logic              empty
);

    localparam logic [10:0]       H_LIM = 11'(H_RES);
    localparam logic [9:0]        V_LIM = 10'(V_RES);
    localparam logic [ADDR_W-1:0] H_ROW = ADDR_W'(H_RES);

    logic [10:0] x_sum;
    logic [9:0]  y_sum;

    // Sums are one bit wider than the operands so the clip compare never wraps.
    always_comb begin
        x_sum    = {1'b0, x} + {1'b0, w};
        y_sum    = {1'b0, y} + {1'b0, h};
        x_end    = (x_sum > H_LIM) ? H_LIM : x_sum;
        y_end    = (y_sum > V_LIM) ? V_LIM : y_sum;
        row_base = ADDR_W'(y) * H_ROW;
        empty    = (w == '0) || (h == '0) || ({1'b0, x} >= H_LIM) || ({1'b0, y} >= V_LIM);
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: one command per handshake, clipped raster-order Avalon-MM pixel writes.
module fb_rect_fill
    import fb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [15:0]       cmd_color,
    output logic [ADDR_W-1:0] avm_address,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_write,
    output logic              avm_chipselect,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] H_ROW = ADDR_W'(H_RES);

    state_e              state;
    logic [9:0]          lx;
    logic [8:0]          ly;
    logic [9:0]          lw;
    logic [8:0]          lh;
    logic [DATA_W-1:0]   color;

    logic [10:0]         x_end;
    logic [9:0]          y_end;
    logic [9:0]          cur_x;
    logic [8:0]          cur_y;
    logic [ADDR_W-1:0]   row_base;

    logic [10:0]         clip_x_end;
    logic [9:0]          clip_y_end;
    logic [ADDR_W-1:0]   clip_row_base;
    logic                clip_empty;

    logic                accept;
    logic                last_col;
    logic                last_row;

    fb_rect_clip u_clip (
        .x        (lx),
        .y        (ly),
        .w        (lw),
        .h        (lh),
        .x_end    (clip_x_end),
        .y_end    (clip_y_end),
        .row_base (clip_row_base),
        .empty    (clip_empty)
    );

    always_comb begin
        cmd_ready      = (state == IDLE);
        busy           = (state != IDLE);
        done           = (state == FINISH);
        avm_write      = (state == WRITE);
        avm_chipselect = avm_write;
        avm_writedata  = color;
        avm_address    = row_base + ADDR_W'(cur_x);
        accept         = avm_write && !avm_waitrequest;
        last_col       = (({1'b0, cur_x} + 11'd1) == x_end);
        last_row       = (({1'b0, cur_y} + 10'd1) == y_end);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            lx       <= '0;
            ly       <= '0;
            lw       <= '0;
            lh       <= '0;
            color    <= '0;
            x_end    <= '0;
            y_end    <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            row_base <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        lx    <= cmd_x;
                        ly    <= cmd_y;
                        lw    <= cmd_w;
                        lh    <= cmd_h;
                        color <= cmd_color;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    x_end    <= clip_x_end;
                    y_end    <= clip_y_end;
                    row_base <= clip_row_base;
                    cur_x    <= lx;
                    cur_y    <= ly;
                    state    <= clip_empty ? FINISH : WRITE;
                end
                WRITE: begin
                    // Row wrap steps the base by one stride; no multiply inside the loop.
                    if (accept) begin
                        if (last_col) begin
                            cur_x    <= lx;
                            cur_y    <= cur_y + 9'd1;
                            row_base <= row_base + H_ROW;
                            if (last_row) begin
                                state <= FINISH;
                            end
                        end else begin
                            cur_x <= cur_x + 10'd1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed self-checking bench for fb_rect_fill with hand-computed pixel addresses and timing.
module tb_fb_rect_fill;
    import fb_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_x;
    logic [8:0]        cmd_y;
    logic [9:0]        cmd_w;
    logic [8:0]        cmd_h;
    logic [15:0]       cmd_color;
    logic [ADDR_W-1:0] avm_address;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_write;
    logic              avm_chipselect;
    logic              avm_waitrequest;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    int wr_addr[$];
    int wr_data[$];
    int held_cycles;
    int held_unstable;

    always #5 clock = ~clock;

    fb_rect_fill dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_x           (cmd_x),
        .cmd_y           (cmd_y),
        .cmd_w           (cmd_w),
        .cmd_h           (cmd_h),
        .cmd_color       (cmd_color),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_write       (avm_write),
        .avm_chipselect  (avm_chipselect),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                           input logic [8:0] h, input logic [15:0] c);
        cmd_x     = x;
        cmd_y     = y;
        cmd_w     = w;
        cmd_h     = h;
        cmd_color = c;
    endtask

    // Returns just after the posedge on which cmd_valid && cmd_ready was sampled.
    task automatic wait_handshake();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            if (cmd_ready) seen = 1'b1;
        end
        if (!seen) check("hs_timeout", 0, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic run_cmd(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                           input logic [8:0] h, input logic [15:0] c,
                           input int stall_beat, input int stall_len, output int done_k);
        int stalled;
        int ready_bad;
        int cs_bad;
        int oob;
        int held_a;
        int held_d;
        wr_addr.delete();
        wr_data.delete();
        held_cycles   = 0;
        held_unstable = 0;
        held_a = 0;
        held_d = 0;
        stalled = 0;
        ready_bad = 0;
        cs_bad = 0;
        oob = 0;
        done_k = -1;
        @(posedge clock);
        #1;
        set_cmd(x, y, w, h, c);
        cmd_valid = 1'b1;
        wait_handshake();
        cmd_valid = 1'b0;
        set_cmd('0, '0, '0, '0, '0);
        for (int k = 1; k <= 300 && done_k < 0; k++) begin
            @(negedge clock);
            avm_waitrequest = avm_write && (wr_addr.size() == stall_beat) && (stalled < stall_len);
            if (avm_waitrequest) stalled++;
            #1;
            if (cmd_ready) ready_bad++;
            if (avm_chipselect != avm_write) cs_bad++;
            if (avm_write && wr_addr.size() == stall_beat) begin
                held_cycles++;
                if (held_cycles == 1) begin
                    held_a = int'(avm_address);
                    held_d = int'(avm_writedata);
                end else if (held_a != int'(avm_address) || held_d != int'(avm_writedata)) begin
                    held_unstable++;
                end
            end
            if (avm_write && !avm_waitrequest) begin
                if (int'(avm_address) >= H_RES * V_RES) oob++;
                wr_addr.push_back(int'(avm_address));
                wr_data.push_back(int'(avm_writedata));
            end
            if (done) done_k = k;
        end
        avm_waitrequest = 1'b0;
        check("ready_low_busy", ready_bad, 0);
        check("chipselect_eq_write", cs_bad, 0);
        check("addr_in_range", oob, 0);
    endtask

    initial begin
        int dk;
        int acc;
        int bad_w;
        int bad_d;
        int d1;
        int d2;
        int hs2;
        int n_at_d1;
        int exp_basic[4] = '{1610, 1611, 1930, 1931};
        int exp_b2b[6]   = '{644, 645, 964, 965, 32100, 32101};
        int exp_b2b_d[6] = '{16'h07E0, 16'h07E0, 16'h07E0, 16'h07E0, 16'h001F, 16'h001F};
        int ex_x[4]      = '{5, 5, 320, 5};
        int ex_y[4]      = '{5, 5, 5, 240};
        int ex_w[4]      = '{0, 4, 4, 4};
        int ex_h[4]      = '{4, 0, 4, 4};

        reset           = 1'b1;
        cmd_valid       = 1'b0;
        avm_waitrequest = 1'b0;
        set_cmd('0, '0, '0, '0, '0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_avm_write", avm_write, 0);
        check("rst_chipselect", avm_chipselect, 0);
        check("rst_address", avm_address, 0);
        check("rst_writedata", avm_writedata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic 2x2 fill
        run_cmd(10'd10, 9'd5, 10'd2, 9'd2, RED, -1, 0, dk);
        check("basic_nwrites", wr_addr.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            check($sformatf("basic_addr%0d", i), wr_addr[i], exp_basic[i]);
            check($sformatf("basic_data%0d", i), wr_data[i], 16'hF800);
        end
        check("basic_done_cycle", dk, 6);

        // Bottom-right corner clipping
        run_cmd(10'd318, 9'd239, 10'd5, 9'd3, WHITE, -1, 0, dk);
        check("corner_nwrites", wr_addr.size(), 2);
        if (wr_addr.size() >= 2) begin
            check("corner_addr0", wr_addr[0], 76798);
            check("corner_addr1", wr_addr[1], 76799);
        end
        check("corner_done_cycle", dk, 4);

        // Empty and off-screen commands
        for (int i = 0; i < 4; i++) begin
            run_cmd(10'(ex_x[i]), 9'(ex_y[i]), 10'(ex_w[i]), 9'(ex_h[i]), BLUE, -1, 0, dk);
            check($sformatf("empty%0d_nwrites", i), wr_addr.size(), 0);
            check($sformatf("empty%0d_done_cycle", i), dk, 2);
        end

        // Waitrequest held for 4 cycles on the second beat
        run_cmd(10'd0, 9'd0, 10'd3, 9'd1, GREEN, 1, 4, dk);
        check("stall_nwrites", wr_addr.size(), 3);
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            check($sformatf("stall_addr%0d", i), wr_addr[i], i);
        end
        check("stall_hold_cycles", held_cycles, 5);
        check("stall_hold_stable", held_unstable, 0);
        check("stall_done_cycle", dk, 9);

        // Reset during a 16-beat fill
        @(posedge clock);
        #1;
        set_cmd(10'd0, 9'd0, 10'd16, 9'd1, RED);
        cmd_valid = 1'b1;
        wait_handshake();
        cmd_valid = 1'b0;
        acc = 0;
        for (int k = 0; k < 50 && acc < 3; k++) begin
            @(negedge clock);
            #1;
            if (avm_write && !avm_waitrequest) acc++;
        end
        check("midrst_beats_before", acc, 3);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("midrst_avm_write", avm_write, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        bad_w = 0;
        bad_d = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (avm_write) bad_w++;
            if (done) bad_d++;
        end
        check("midrst_no_writes", bad_w, 0);
        check("midrst_no_done", bad_d, 0);
        run_cmd(10'd0, 9'd0, 10'd1, 9'd1, BLUE, -1, 0, dk);
        check("midrst_next_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() >= 1) check("midrst_next_addr", wr_addr[0], 0);
        check("midrst_next_done_cycle", dk, 3);

        // Back-to-back: cmd_valid held across two commands
        @(posedge clock);
        #1;
        set_cmd(10'd4, 9'd2, 10'd2, 9'd2, GREEN);
        cmd_valid = 1'b1;
        wait_handshake();
        set_cmd(10'd100, 9'd100, 10'd2, 9'd1, BLUE);
        wr_addr.delete();
        wr_data.delete();
        d1 = -1;
        d2 = -1;
        hs2 = -1;
        n_at_d1 = -1;
        for (int k = 1; k <= 100 && d2 < 0; k++) begin
            @(negedge clock);
            #1;
            if (avm_write && !avm_waitrequest) begin
                wr_addr.push_back(int'(avm_address));
                wr_data.push_back(int'(avm_writedata));
            end
            if (done) begin
                if (d1 < 0) begin
                    d1 = k;
                    n_at_d1 = wr_addr.size();
                end else begin
                    d2 = k;
                end
            end
            if (cmd_ready && hs2 < 0) begin
                hs2 = k;
                @(posedge clock);
                #1;
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check("b2b_done1_cycle", d1, 6);
        check("b2b_hs2_cycle", hs2, 7);
        check("b2b_done2_cycle", d2, 11);
        check("b2b_first_writes", n_at_d1, 4);
        check("b2b_total_writes", wr_addr.size(), 6);
        for (int i = 0; i < 6 && i < wr_addr.size(); i++) begin
            check($sformatf("b2b_addr%0d", i), wr_addr[i], exp_b2b[i]);
            check($sformatf("b2b_data%0d", i), wr_data[i], exp_b2b_d[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
